// File: rtl/uart_fifo_mmio.sv
// rtl/uart_fifo_mmio.sv - memory-mapped 8N1 UART with TX/RX FIFOs, baud divisor and sticky error flags
// Byte FIFO helper first, then the bus-facing top with TX serializer and RX sampler.

module uart_fifo_mmio_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Callers gate push/pop so the FIFO never overflows or underflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];
endmodule

module uart_fifo_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int          TX_DEPTH   = 8,
  parameter int          RX_DEPTH   = 8,
  parameter logic [15:0] BAUD_RESET = 16'h3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic [3:0]  write_mask,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        hit,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic sel_data, sel_status, sel_baud;
  logic rd_acc, data_wr, baud_wr, data_rd, status_rd;
  logic [15:0] baud;
  logic overflow, frame_err, overrun;
  logic unused_bus;

  assign sel_data   = (address == BASE_ADDR);
  assign sel_status = (address == BASE_ADDR + 32'h005);
  assign sel_baud   = (address == BASE_ADDR + 32'h100);
  assign hit        = sel_data | sel_status | sel_baud;

  // A write in the same cycle as a read wins; the read is dropped entirely.
  assign rd_acc     = read_enable & hit & ~write_enable;
  assign data_wr    = write_enable & sel_data & write_mask[0];
  assign baud_wr    = write_enable & sel_baud & (&write_mask[1:0]);
  assign data_rd    = rd_acc & sel_data;
  assign status_rd  = rd_acc & sel_status;
  assign unused_bus = ^{write_data[31:16], write_mask[3:2]};

  // TX FIFO and serializer
  logic [7:0]     tx_head;
  logic [TCW-1:0] tx_count;
  logic           tx_full, tx_empty, tx_push, tx_load, tx_busy;
  tx_state_t      tx_state;
  logic [3:0]     tx_bit;
  logic [15:0]    tx_cnt, tx_div;
  logic [7:0]     tx_data;

  assign tx_full  = (tx_count == TCW'(TX_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign tx_push  = data_wr & ~tx_full;
  assign tx_load  = ~tx_empty & ((tx_state == TX_IDLE) ||
                                 (tx_cnt == tx_div && tx_bit == 4'd9));
  assign tx_busy  = ~tx_empty | (tx_state == TX_SHIFT);

  uart_fifo_mmio_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_load),
    .din(write_data[7:0]), .head(tx_head), .count(tx_count)
  );

  // tx_bit: 0 start, 1..8 data, 9 stop; divisor is re-latched at every bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_bit   <= '0;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_data  <= '0;
    end else if (tx_load) begin
      tx_state <= TX_SHIFT;
      tx       <= 1'b0;
      tx_bit   <= '0;
      tx_cnt   <= '0;
      tx_div   <= baud;
      tx_data  <= tx_head;
    end else if (tx_state == TX_SHIFT) begin
      if (tx_cnt == tx_div) begin
        tx_cnt <= '0;
        tx_div <= baud;
        if (tx_bit == 4'd9) begin
          tx_state <= TX_IDLE;
          tx       <= 1'b1;
        end else begin
          tx_bit <= tx_bit + 4'd1;
          tx     <= (tx_bit == 4'd8) ? 1'b1 : tx_data[tx_bit[2:0]];
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

  // RX sampler and FIFO
  logic [7:0]     rx_head;
  logic [RCW-1:0] rx_count;
  logic           rx_full, rx_empty, rx_pop, rx_push;
  logic           rx_s1, rx_s2, rx_s3;
  rx_state_t      rx_state;
  logic [15:0]    rx_cnt, rx_half_m1;
  logic [2:0]     rx_nbit;
  logic [7:0]     rx_shift;
  logic           rx_stop_smp, rx_good, rx_bad;

  assign rx_full     = (rx_count == RCW'(RX_DEPTH));
  assign rx_empty    = (rx_count == '0);
  assign rx_pop      = data_rd & ~rx_empty;
  assign rx_stop_smp = (rx_state == RX_STOP) && (rx_cnt == 16'd0);
  assign rx_good     = rx_stop_smp & rx_s2;
  assign rx_bad      = rx_stop_smp & ~rx_s2;
  assign rx_push     = rx_good & (~rx_full | rx_pop);
  // floor((D+1)/2) - 1, clamped at 0, so the start bit is sampled mid-bit
  assign rx_half_m1  = (baud[0] || baud == 16'd0) ? (baud >> 1) : ((baud >> 1) - 16'd1);

  uart_fifo_mmio_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
    .din(rx_shift), .head(rx_head), .count(rx_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_nbit  <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          if (rx_s3 & ~rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= rx_half_m1;
          end
        end
        RX_START: begin
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else if (rx_s2) rx_state <= RX_IDLE;
          else begin
            rx_state <= RX_DATA;
            rx_cnt   <= baud;
            rx_nbit  <= '0;
          end
        end
        RX_DATA: begin
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= baud;
            rx_nbit  <= rx_nbit + 3'd1;
            if (rx_nbit == 3'd7) rx_state <= RX_STOP;
          end
        end
        default: begin
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  // Registers, sticky flags (set beats clear), read path, irq
  logic [7:0]  status;
  logic [31:0] rd_mux;

  assign status = {1'b0, tx_busy, tx_full, 1'b0, overflow, frame_err, overrun, ~rx_empty};

  always_comb begin
    rd_mux = '0;
    if (sel_data)   rd_mux = {24'b0, rx_empty ? 8'h00 : rx_head};
    if (sel_status) rd_mux = {24'b0, status};
    if (sel_baud)   rd_mux = {16'b0, baud};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud       <= BAUD_RESET;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      read_data  <= '0;
      read_valid <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (baud_wr) baud <= write_data[15:0];
      overflow   <= (data_wr & tx_full) | (overflow & ~status_rd);
      frame_err  <= rx_bad | (frame_err & ~status_rd);
      overrun    <= (rx_good & rx_full & ~rx_pop) | (overrun & ~status_rd);
      read_valid <= rd_acc;
      if (rd_acc) read_data <= rd_mux;
      irq        <= ~rx_empty | overrun | frame_err;
    end
  end
endmodule
